// File: rtl/fb_write_arbiter_if.sv
// fb_write_arbiter_if: producer handshakes, clear control and framebuffer write port of fb_write_arbiter.
interface fb_write_arbiter_if #(parameter int DW = 8);
    logic          cam_valid, cam_ready;
    logic [10:0]   cam_x, cam_y;
    logic [DW-1:0] cam_data;
    logic          ovl_valid, ovl_ready;
    logic [10:0]   ovl_x, ovl_y;
    logic [DW-1:0] ovl_data;
    logic          clear_req, clear_busy;
    logic [DW-1:0] clear_color;
    logic          fb_we;
    logic [10:0]   fb_x, fb_y;
    logic [DW-1:0] fb_data;
    logic [15:0]   drop_count;
    modport master (
        output cam_valid, cam_x, cam_y, cam_data,
        output ovl_valid, ovl_x, ovl_y, ovl_data,
        output clear_req, clear_color,
        input  cam_ready, ovl_ready, clear_busy,
        input  fb_we, fb_x, fb_y, fb_data, drop_count
    );
    modport slave (
        input  cam_valid, cam_x, cam_y, cam_data,
        input  ovl_valid, ovl_x, ovl_y, ovl_data,
        input  clear_req, clear_color,
        output cam_ready, ovl_ready, clear_busy,
        output fb_we, fb_x, fb_y, fb_data, drop_count
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin camera/overlay arbiter owning the framebuffer write port.
// The full-screen clear sweep is built only when FB_CLEAR_EN is defined.
module fb_write_arbiter #(
    parameter int FB_W = 320,
    parameter int FB_H = 240,
    parameter int DW   = 8
) (
    input logic               CLOCK_50,
    input logic               reset,
    fb_write_arbiter_if.slave bus
);
    localparam logic [10:0] XMAX = 11'(FB_W - 1);
    localparam logic [10:0] YMAX = 11'(FB_H - 1);
    localparam logic [10:0] W    = 11'(FB_W);
    localparam logic [10:0] H    = 11'(FB_H);

    logic          last_ovl, clearing, starting;
    logic [10:0]   cx, cy;
    logic [DW-1:0] color;
    logic          grant_cam, grant_ovl, xfer, in_range;
    logic [10:0]   sel_x, sel_y;
    logic [DW-1:0] sel_data;

`ifdef FB_CLEAR_EN
    typedef enum logic {RUN, CLEAR} state_t;
    state_t state, state_nxt;

    always_ff @(posedge CLOCK_50)
        state <= reset ? RUN : state_nxt;

    always_comb begin
        state_nxt = state;
        if (state == RUN && bus.clear_req)
            state_nxt = CLEAR;
        else if (state == CLEAR && cx == XMAX && cy == YMAX)
            state_nxt = RUN;
    end

    assign clearing = state == CLEAR;
    assign starting = state == RUN && bus.clear_req;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cx    <= '0;
            cy    <= '0;
            color <= '0;
        end else if (starting) begin
            cx    <= '0;
            cy    <= '0;
            color <= bus.clear_color;
        end else if (clearing) begin
            cx <= cx == XMAX ? 11'd0 : cx + 11'd1;
            cy <= cx != XMAX ? cy : cy == YMAX ? 11'd0 : cy + 11'd1;
        end
    end
`else
    logic unused_clear;
    assign clearing     = 1'b0;
    assign starting     = 1'b0;
    assign cx           = '0;
    assign cy           = '0;
    assign color        = '0;
    assign unused_clear = ^{bus.clear_req, bus.clear_color};
`endif

    // A sweep, including its entry cycle, locks both producers out.
    always_comb begin
        grant_cam = !clearing && !starting && bus.cam_valid && (!bus.ovl_valid || last_ovl);
        grant_ovl = !clearing && !starting && bus.ovl_valid && (!bus.cam_valid || !last_ovl);
        xfer      = grant_cam || grant_ovl;
        sel_x     = grant_cam ? bus.cam_x : bus.ovl_x;
        sel_y     = grant_cam ? bus.cam_y : bus.ovl_y;
        sel_data  = grant_cam ? bus.cam_data : bus.ovl_data;
        in_range  = sel_x < W && sel_y < H;
    end

    assign bus.cam_ready  = grant_cam && !reset;
    assign bus.ovl_ready  = grant_ovl && !reset;
    assign bus.clear_busy = clearing;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bus.fb_we      <= 1'b0;
            bus.fb_x       <= '0;
            bus.fb_y       <= '0;
            bus.fb_data    <= '0;
            bus.drop_count <= '0;
            last_ovl       <= 1'b1;
        end else if (clearing) begin
            bus.fb_we   <= 1'b1;
            bus.fb_x    <= cx;
            bus.fb_y    <= cy;
            bus.fb_data <= color;
        end else begin
            bus.fb_we <= xfer && in_range;
            if (xfer)
                last_ovl <= grant_ovl;
            if (xfer && in_range) begin
                bus.fb_x    <= sel_x;
                bus.fb_y    <= sel_y;
                bus.fb_data <= sel_data;
            end
            if (xfer && !in_range && bus.drop_count != 16'hFFFF)
                bus.drop_count <= bus.drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed and randomized checks of fb_write_arbiter against a pixel-level model.
module tb_fb_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    bit          m_last_ovl;
    logic        m_we;
    logic [10:0] m_x, m_y;
    logic [7:0]  m_data;
    int          m_drop;

    fb_write_arbiter_if #(.DW(8)) bus ();
    fb_write_arbiter #(.FB_W(320), .FB_H(240), .DW(8)) dut (.CLOCK_50(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: predict grants from the round-robin rule, then the registered write.
    task automatic cycle(output bit gc, output bit go);
        bit both;
        int x, y;
        logic [7:0] d;
        #1;
        both = bus.cam_valid && bus.ovl_valid;
        gc = both ? m_last_ovl : bus.cam_valid;
        go = both ? !m_last_ovl : bus.ovl_valid;
        x = gc ? int'(bus.cam_x) : int'(bus.ovl_x);
        y = gc ? int'(bus.cam_y) : int'(bus.ovl_y);
        d = gc ? bus.cam_data : bus.ovl_data;
        chk("cam_ready", bus.cam_ready, gc);
        chk("ovl_ready", bus.ovl_ready, go);
        @(posedge clk);
        m_we = 1'b0;
        if (gc || go) begin
            m_last_ovl = go;
            if (x < 320 && y < 240) begin
                m_we = 1'b1;
                m_x = 11'(x);
                m_y = 11'(y);
                m_data = d;
            end else begin
                m_drop = m_drop < 65535 ? m_drop + 1 : 65535;
            end
        end
        #1;
        chk("fb_we", bus.fb_we, m_we);
        chk("fb_x", bus.fb_x, m_x);
        chk("fb_y", bus.fb_y, m_y);
        chk("fb_data", bus.fb_data, m_data);
        chk("drop_count", bus.drop_count, m_drop);
        chk("clear_busy", bus.clear_busy, 0);
    endtask

    task automatic set_cam(input int x, input int y, input logic [7:0] d);
        bus.cam_x = 11'(x);
        bus.cam_y = 11'(y);
        bus.cam_data = d;
    endtask

    initial begin
        bit gc, go;
        int bad, busy_bad;
        m_last_ovl = 1'b1;
        m_we = 1'b0; m_x = '0; m_y = '0; m_data = '0; m_drop = 0;
        bus.cam_valid = 1'b1; set_cam(0, 0, 8'h00);
        bus.ovl_valid = 1'b0; bus.ovl_x = '0; bus.ovl_y = '0; bus.ovl_data = '0;
        bus.clear_req = 1'b0; bus.clear_color = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fb_we", bus.fb_we, 0);
        chk("rst_fb_x", bus.fb_x, 0);
        chk("rst_fb_y", bus.fb_y, 0);
        chk("rst_fb_data", bus.fb_data, 0);
        chk("rst_drop", bus.drop_count, 0);
        chk("rst_busy", bus.clear_busy, 0);
        chk("rst_cam_ready", bus.cam_ready, 0);
        chk("rst_ovl_ready", bus.ovl_ready, 0);
        bus.cam_valid = 1'b0;
        rst = 1'b0;
        cycle(gc, go);
        // Tie: camera wins first, then strict alternation; each side changes data only once served.
        bus.cam_valid = 1'b1; bus.ovl_valid = 1'b1;
        set_cam(1, 1, 8'hC0);
        bus.ovl_x = 11'd2; bus.ovl_y = 11'd2;
        for (int i = 0; i < 4; i++) begin
            bus.cam_data = 8'(8'hC0 + (i + 1) / 2);
            bus.ovl_data = 8'(8'hD0 + i / 2);
            cycle(gc, go);
            chk("tie_we", bus.fb_we, 1);
            chk("tie_data", bus.fb_data, 8'((i % 2 == 1 ? 8'hD0 : 8'hC0) + i / 2));
        end
        bus.cam_valid = 1'b0; bus.ovl_valid = 1'b0;
        cycle(gc, go);
        bus.cam_valid = 1'b1; set_cam(10, 20, 8'hAB);
        cycle(gc, go);
        chk("single_x", bus.fb_x, 10);
        chk("single_y", bus.fb_y, 20);
        chk("single_data", bus.fb_data, 8'hAB);
        bus.cam_valid = 1'b0;
        cycle(gc, go);
        chk("single_we_off", bus.fb_we, 0);
        bus.cam_valid = 1'b1; set_cam(320, 0, 8'h11);
        cycle(gc, go);
        chk("drop_one", bus.drop_count, 1);
        chk("drop_no_we", bus.fb_we, 0);
        bus.cam_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.cam_valid || gc) begin
                bus.cam_valid = $urandom_range(0, 2) != 0;
                set_cam($urandom_range(0, 339), $urandom_range(0, 259), 8'($urandom));
            end
            if (!bus.ovl_valid || go) begin
                bus.ovl_valid = $urandom_range(0, 2) != 0;
                bus.ovl_x = 11'($urandom_range(0, 339));
                bus.ovl_y = 11'($urandom_range(0, 259));
                bus.ovl_data = 8'($urandom);
            end
            cycle(gc, go);
        end
        bus.cam_valid = 1'b0; bus.ovl_valid = 1'b0;
        cycle(gc, go);
`ifndef FB_CLEAR_EN
        bus.clear_req = 1'b1; bus.clear_color = 8'h33;
        bus.cam_valid = 1'b1; set_cam(7, 8, 8'h44);
        cycle(gc, go);
        bus.cam_valid = 1'b0;
        cycle(gc, go);
        bus.clear_req = 1'b0;
        bus.cam_valid = 1'b1; set_cam(320, 0, 8'h00);
        repeat (65540) @(posedge clk);
        #1;
        chk("drop_saturated", bus.drop_count, 16'hFFFF);
        chk("drop_sat_we", bus.fb_we, 0);
        m_drop = 65535;
        cycle(gc, go);
        bus.cam_valid = 1'b0;
        cycle(gc, go);
`else
        bus.cam_valid = 1'b1; set_cam(5, 5, 8'h77);
        bus.ovl_valid = 1'b1;
        bus.clear_req = 1'b1; bus.clear_color = 8'h1C;
        #1;
        chk("clr_req_cam_ready", bus.cam_ready, 0);
        chk("clr_req_ovl_ready", bus.ovl_ready, 0);
        bus.ovl_valid = 1'b0;
        @(posedge clk); #1;
        bus.clear_req = 1'b0; bus.clear_color = 8'h55;
        chk("clr_busy_on", bus.clear_busy, 1);
        chk("clr_entry_we", bus.fb_we, 0);
        bad = 0; busy_bad = 0;
        for (int k = 0; k < 76800; k++) begin
            bus.clear_req = k == 500;
            @(posedge clk); #1;
            if (bus.fb_we !== 1'b1 || int'(bus.fb_x) !== k % 320 || int'(bus.fb_y) !== k / 320 || bus.fb_data !== 8'h1C)
                bad++;
            if (k < 76799 && (bus.clear_busy !== 1'b1 || bus.cam_ready !== 1'b0 || bus.ovl_ready !== 1'b0))
                busy_bad++;
            if (k == 0) begin
                chk("clr_first_x", bus.fb_x, 0);
                chk("clr_first_y", bus.fb_y, 0);
            end
            if (k == 320) begin
                chk("clr_321_x", bus.fb_x, 0);
                chk("clr_321_y", bus.fb_y, 1);
            end
        end
        chk("clr_last_x", bus.fb_x, 319);
        chk("clr_last_y", bus.fb_y, 239);
        chk("clr_bad_pixels", bad, 0);
        chk("clr_busy_bad", busy_bad, 0);
        chk("clr_busy_off", bus.clear_busy, 0);
        chk("clr_done_cam_ready", bus.cam_ready, 1);
        @(posedge clk); #1;
        chk("post_clr_we", bus.fb_we, 1);
        chk("post_clr_x", bus.fb_x, 5);
        chk("post_clr_y", bus.fb_y, 5);
        chk("post_clr_data", bus.fb_data, 8'h77);
        bus.cam_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_clr_idle_we", bus.fb_we, 0);
        chk("post_clr_idle_busy", bus.clear_busy, 0);
        bus.cam_valid = 1'b1; set_cam(5, 6, 8'h99);
        bus.clear_req = 1'b1; bus.clear_color = 8'hE0;
        @(posedge clk); #1;
        bus.clear_req = 1'b0;
        repeat (1001) @(posedge clk);
        #1;
        chk("mid_px_x", bus.fb_x, 40);
        chk("mid_px_y", bus.fb_y, 3);
        chk("mid_px_data", bus.fb_data, 8'hE0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", bus.clear_busy, 0);
        chk("mid_rst_we", bus.fb_we, 0);
        chk("mid_rst_cam_ready", bus.cam_ready, 0);
        rst = 1'b0;
        m_last_ovl = 1'b1;
        m_we = 1'b0; m_x = '0; m_y = '0; m_data = '0; m_drop = 0;
        cycle(gc, go);
        chk("mid_rst_xfer", bus.fb_y, 6);
        bus.cam_valid = 1'b0;
        repeat (5) cycle(gc, go);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Write-side controller for the 320x240, 8-bit-per-pixel framebuffer. It shares the framebuffer's single write port between two pixel producers, the camera capture path and the overlay drawer, using round-robin arbitration with valid/ready handshakes. It also runs an optional full-screen clear sweep. The block sits directly in front of the framebuffer's write_enable/data_in/data_in_x/data_in_y inputs and owns them exclusively.

## Interface
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels
- DW, 8, pixel width in bits
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cam_valid / cam_ready  in / out  1 / 1  camera handshake
- cam_x, cam_y  in  11 each  camera pixel coordinates
- cam_data  in  DW  camera pixel value
- ovl_valid / ovl_ready  in / out  1 / 1  overlay handshake
- ovl_x, ovl_y  in  11 each  overlay pixel coordinates
- ovl_data  in  DW  overlay pixel value
- clear_req  in  1  start a clear sweep (level, sampled each cycle)
- clear_color  in  DW  fill value, latched when clear_req is accepted
- clear_busy  out  1  high while a sweep runs
- fb_we  out  1  framebuffer write enable (registered)
- fb_x, fb_y  out  11 each  framebuffer write coordinates (registered)
- fb_data  out  DW  framebuffer write data (registered)
- drop_count  out  16  saturating count of dropped out-of-range writes

## Operation
- States: RUN and CLEAR. Reset enters RUN.
- **RUN arbitration** is combinational from the valid signals and a last_grant bit.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester not granted last is granted.
  - last_grant resets to overlay, so the camera wins the first tie.
  - Only the granted requester sees ready=1. A transfer is valid&&ready. At most one transfer per cycle.
- **Transfer handling:** on a transfer, last_grant updates to the granted requester.
  - Coordinates in range (x<FB_W, y<FB_H): fb_x/fb_y/fb_data load the transferred values and fb_we=1 on the next edge.
  - Coordinates out of range: the transfer is still accepted (ready stays high), fb_we=0, and drop_count increments, saturating at 0xFFFF.
- **No transfer:** fb_we=0 on the next edge. fb_x/fb_y/fb_data hold their values.
- **Clear entry:** clear_req=1 in RUN has priority over both requesters; both readies are 0 in that cycle. At the edge: state goes to CLEAR, clear_color is latched, and sweep counters go to (0,0).
- **CLEAR sweep:** both readies are held at 0. Each edge writes one pixel: fb_we=1, fb_data=latched color, and fb_x/fb_y=counters.
  - x runs 0..FB_W-1 as the inner loop; y runs 0..FB_H-1 as the outer loop.
  - The edge that writes (FB_W-1, FB_H-1) returns the state to RUN.
- clear_req while in CLEAR is ignored. No sweep is queued.
- clear_busy = (state==CLEAR).
- **Reset** (including mid-sweep) aborts any sweep and returns to RUN. Reset values:
  - fb_we, fb_x, fb_y, fb_data, drop_count, and the sweep counters: 0
  - clear_busy: 0; both readies: 0 while reset is high
  - last_grant: overlay
- Requester data is not buffered. A producer must hold its valid, coordinates and data stable until ready.

## Timing
- Write latency is 1 cycle. A transfer at edge N produces fb_we=1 with that pixel during the cycle after edge N.
- Sustained throughput is 1 pixel/cycle. Under a two-way tie, each requester gets every other cycle.
- **Clear timing,** with clear_req sampled at edge N:
  - clear_busy is high from edge N.
  - Pixel k (k = y*FB_W + x) is output at edge N+1+k.
  - The last pixel is output at edge N+FB_W*FB_H (N+76800), and clear_busy falls at that same edge.
  - The first requester transfer can occur in the following cycle.
- Reset has priority over every other event in the same cycle.

## Configuration
- FB_CLEAR_EN defined: the clear FSM, color latch and sweep counters are built as described above.
- FB_CLEAR_EN undefined:
  - clear_req and clear_color are ignored, clear_busy is tied to 0, and the block is permanently in RUN.
  - Arbitration, the drop logic and all timing are otherwise identical.

## Test plan
- **Reset values:** assert reset for 3 cycles → all outputs 0, cam_ready=ovl_ready=0.
- **Single camera write:** cam_valid with (10,20,0xAB) held one cycle → cam_ready=1 that cycle; next cycle fb_we=1, fb_x=10, fb_y=20, fb_data=0xAB; the cycle after, fb_we=0.
- **Tie arbitration:** both valid continuously for 4 cycles → grants go cam, ovl, cam, ovl; fb_data sequence matches, with fb_we=1 every cycle.
- **Out-of-range drop:** cam write at x=320, y=0 → accepted, fb_we stays 0, drop_count=1. After 70000 such drops, drop_count reads 0xFFFF.
- **Clear sweep (FB_CLEAR_EN):** clear_req pulse with clear_color=0x1C while cam_valid is held high → exactly 76800 consecutive fb_we=1 cycles.
  - First write is (0,0), the 321st is (0,1), and the last is (319,239), all with data 0x1C.
  - cam_ready stays 0 throughout and rises the cycle after clear_busy falls.
- **Reset mid-sweep:** assert reset at pixel 1000 of a sweep → clear_busy=0 and fb_we=0 after the edge; once reset releases, the next cam transfer is accepted immediately and no further clear pixels are written.
